muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers, sitting beside the EX-stage ALU.
- Accepts one operation from EX.
- Iterates a shift-add multiplier or restoring divider for a fixed number of cycles.
- Writes HI/LO and serves MFHI/MFLO/MTHI/MTLO.
- Raises stall_out so the hazard logic freezes the pipeline, IF/ID and ID/EX, while a result is pending.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width (must hold WIDTH-1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start_in  in  1  EX holds a mult/div instruction this cycle
op_in  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_in
a_in  in  WIDTH  rs operand (forwarded value)
b_in  in  WIDTH  rt operand (forwarded value)
read_hilo_in  in  1  EX holds MFHI or MFLO
hi_we_in  in  1  MTHI
lo_we_in  in  1  MTLO
wdata_in  in  WIDTH  MTHI/MTLO data
hi_out  out  WIDTH  HI register
lo_out  out  WIDTH  LO register
busy_out  out  1  operation in progress
done_out  out  1  one-cycle pulse, HI/LO just updated
stall_out  out  1  pipeline freeze request

Behaviour:
- Reset (asynchronous, active-low):
  - State IDLE, counter 0, all working registers 0.
  - hi_out = lo_out = 0, busy_out = done_out = stall_out = 0.
  - Reset asserted mid-operation aborts it. HI/LO return to 0 and no done_out is produced.
- States IDLE, RUN, FIX.
- IDLE:
  - start_in = 1 at a rising edge captures the operands.
    - Signed ops capture magnitudes |a|, |b| and record sign_q = a[31]^b[31] and sign_r = a[31].
    - Unsigned ops record both signs as 0.
  - The same edge clears the accumulator and counter and moves to RUN.
- RUN, one iteration per edge for WIDTH edges (counter 0..WIDTH-1):
  - Multiply: shift-add producing a 2*WIDTH-bit product.
  - Divide: restoring shift/subtract producing quotient and remainder.
  - counter == WIDTH-1 at an edge moves to FIX.
- FIX, one edge:
  - Applies sign correction in two's complement.
    - Product is negated if sign_q.
    - Quotient is negated if sign_q.
    - Remainder is negated if sign_r.
  - Writes HI/LO: MULT sets HI = product[63:32] and LO = product[31:0]; DIV sets LO = quotient and HI = remainder.
  - Moves to IDLE. done_out = 1 for the following cycle only.
- Latency: busy_out is high for exactly WIDTH+1 = 33 cycles, starting the cycle after the start edge. New HI/LO are visible in the first cycle busy_out is low.
- Divide by zero (b_in == 0, detected at capture): same 33-cycle latency. Result is LO = all-ones and HI = a_in, unmodified and regardless of sign.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. Wraps naturally, no trap.
- stall_out = busy_out & (start_in | read_hilo_in | hi_we_in | lo_we_in). It is combinational, so there is no stall for instructions unrelated to HI/LO.
- While busy: start_in, hi_we_in and lo_we_in are ignored. The pipeline holds them via stall_out and they are re-presented once idle.
- IDLE writes: hi_we_in / lo_we_in write wdata_in at the edge; both may be set in the same cycle.
- Simultaneous start_in and hi_we_in/lo_we_in in IDLE: start wins and the writes are discarded. The decoder never issues both.
- MFHI/MFLO read hi_out/lo_out combinationally in EX. There is no extra latency when idle.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU
  - state encoding ST_IDLE/ST_RUN/ST_FIX
  - WIDTH default
- One combinational sub-module, muldiv_step, performs a single iteration given accumulator, operand and mode. It returns the next accumulator and the quotient bit.
- The FSM, counter, sign registers and HI/LO live in muldiv_sequencer.

Test Plan:
- MULTU a=FFFFFFFF, b=FFFFFFFF → busy_out high 33 cycles, done_out pulse, then HI=FFFFFFFE, LO=00000001.
- MULT a=FFFFFFFD (-3), b=00000007 → HI=FFFFFFFF, LO=FFFFFFEB. DIV a=FFFFFFF9 (-7), b=00000002 → LO=FFFFFFFD, HI=FFFFFFFF.
- DIVU a=00000064, b=0 → after 33 cycles LO=FFFFFFFF, HI=00000064. DIV 80000000/FFFFFFFF → LO=80000000, HI=0.
- Start MULTU 3*5, then assert read_hilo_in on cycle 2 → stall_out high until busy_out falls. In the first idle cycle lo_out=0000000F with no stall. A second start_in during busy leaves HI/LO unaffected.
- In IDLE, hi_we_in=1 with wdata=12345678 → hi_out=12345678 next cycle. Assert lo_we_in while busy → stall_out=1 and LO unchanged until the op completes.
- Assert reset low at RUN cycle 10 → state IDLE and HI/LO = 0 immediately, no done_out. A new MULTU 2*2 after release gives LO=4.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 6;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or the restoring divider.
// Multiply: accIn = {partial high, product bits shifted in so far}, aBit is
// the current multiplier LSB. Divide: accIn = {remainder, quotient so far},
// aBit is the next dividend bit; the new quotient bit is returned in qBit
// and its slot in accOut is left zero for the caller to fill.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] accIn,
   input  logic [WIDTH-1:0]   divisor,
   input  logic               aBit,
   input  logic               isDiv,
   output logic [2*WIDTH-1:0] accOut,
   output logic               qBit
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] remNext;

   // Single iteration datapath for both modes.
   always_comb begin
      sum     = '0;
      shifted = '0;
      diff    = '0;
      remNext = '0;
      qBit    = 1'b0;
      accOut  = accIn;
      if (isDiv) begin
         shifted = {accIn[2*WIDTH-1:WIDTH], aBit};
         diff    = shifted - {1'b0, divisor};
         if (!diff[WIDTH]) begin
            qBit    = 1'b1;
            remNext = diff[WIDTH-1:0];
         end else begin
            remNext = shifted[WIDTH-1:0];
         end
         accOut = {remNext, accIn[WIDTH-2:0], 1'b0};
      end else begin
         sum    = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (aBit ? {1'b0, divisor} : '0);
         accOut = {sum, accIn[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operands are reduced to magnitudes at capture, iterated for WIDTH cycles,
// then sign-corrected and written to HI/LO in a single FIX cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   ST_IDLE | HI/LO architectural, MTHI/MTLO accepted, waits start
//   ST_RUN  | one shift-add / restoring-divide iteration per edge
//   ST_FIX  | sign correction, HI/LO write, done pulse follows
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_in,
   input  logic [1:0]       op_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             read_hilo_in,
   input  logic             hi_we_in,
   input  logic             lo_we_in,
   input  logic [WIDTH-1:0] wdata_in,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy_out,
   output logic             done_out,
   output logic             stall_out
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state;
   state_t             nextState;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opA;
   logic [WIDTH-1:0]   opB;
   logic               signQ;
   logic               signR;
   logic               divZero;
   logic               isDivQ;
   logic [WIDTH-1:0]   hiQ;
   logic [WIDTH-1:0]   loQ;
   logic               doneQ;

   logic               isSignedOp;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic               aBit;
   logic [2*WIDTH-1:0] stepAcc;
   logic               stepQ;
   logic [2*WIDTH-1:0] prodFix;
   logic [WIDTH-1:0]   quoFix;
   logic [WIDTH-1:0]   remFix;

   // Operand magnitudes and final sign correction.
   always_comb begin
      isSignedOp = (op_in == OP_MULT) || (op_in == OP_DIV);
      magA       = (isSignedOp && a_in[WIDTH-1]) ? -a_in : a_in;
      magB       = (isSignedOp && b_in[WIDTH-1]) ? -b_in : b_in;
      aBit       = isDivQ ? opA[WIDTH-1] : opA[0];
      prodFix    = signQ ? -acc : acc;
      quoFix     = signQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      remFix     = signR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   muldiv_step #(.WIDTH(WIDTH)) uStep (
      .accIn   (acc),
      .divisor (opB),
      .aBit    (aBit),
      .isDiv   (isDivQ),
      .accOut  (stepAcc),
      .qBit    (stepQ)
   );

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= nextState;
   end

   // Next state, busy and pipeline stall request.
   always_comb begin
      nextState = state;
      busy_out  = (state != ST_IDLE);
      stall_out = busy_out & (start_in | read_hilo_in | hi_we_in | lo_we_in);
      case (state)
         ST_IDLE: if (start_in) nextState = ST_RUN;
         ST_RUN:  if (cnt == LAST_CNT) nextState = ST_FIX;
         ST_FIX:  nextState = ST_IDLE;
         default: nextState = ST_IDLE;
      endcase
   end

   // Operand capture, iteration, HI/LO update and done pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         acc     <= '0;
         opA     <= '0;
         opB     <= '0;
         signQ   <= 1'b0;
         signR   <= 1'b0;
         divZero <= 1'b0;
         isDivQ  <= 1'b0;
         hiQ     <= '0;
         loQ     <= '0;
         doneQ   <= 1'b0;
      end else begin
         doneQ <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_in) begin
                  opA     <= magA;
                  opB     <= magB;
                  signQ   <= isSignedOp & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                  signR   <= isSignedOp & a_in[WIDTH-1];
                  divZero <= (b_in == '0);
                  isDivQ  <= op_in[1];
                  acc     <= '0;
                  cnt     <= '0;
               end else begin
                  if (hi_we_in) hiQ <= wdata_in;
                  if (lo_we_in) loQ <= wdata_in;
               end
            end
            ST_RUN: begin
               acc <= stepAcc | {{(2*WIDTH-1){1'b0}}, stepQ};
               cnt <= cnt + CNT_W'(1);
               opA <= isDivQ ? {opA[WIDTH-2:0], 1'b0} : {1'b0, opA[WIDTH-1:1]};
            end
            ST_FIX: begin
               // A zero divisor leaves remainder = |a|, so the remainder
               // sign fix restores a itself; the quotient is forced to ones.
               if (isDivQ) begin
                  loQ <= divZero ? '1 : quoFix;
                  hiQ <= remFix;
               end else begin
                  {hiQ, loQ} <= prodFix;
               end
               doneQ <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign hi_out   = hiQ;
   assign lo_out   = loQ;
   assign done_out = doneQ;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised and directed checks of muldiv_sequencer against an arithmetic
// reference model.
module tb_muldiv_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        start_in;
   logic [1:0]  op_in;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        read_hilo_in;
   logic        hi_we_in;
   logic        lo_we_in;
   logic [31:0] wdata_in;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        busy_out;
   logic        done_out;
   logic        stall_out;

   int nChecks = 0;
   int nErrors = 0;

   muldiv_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .start_in     (start_in),
      .op_in        (op_in),
      .a_in         (a_in),
      .b_in         (b_in),
      .read_hilo_in (read_hilo_in),
      .hi_we_in     (hi_we_in),
      .lo_we_in     (lo_we_in),
      .wdata_in     (wdata_in),
      .hi_out       (hi_out),
      .lo_out       (lo_out),
      .busy_out     (busy_out),
      .done_out     (done_out),
      .stall_out    (stall_out)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: observed %h, expected %h", tag, got, exp);
      end
   endtask

   // {HI, LO} as the architecture defines them.
   function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: p = 64'(sa * sb);
         2'b01: p = {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 0) p = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 0) p = {a, 32'hFFFF_FFFF};
            else        p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   task automatic waitIdle(inout int cycles);
      while (busy_out && cycles < 100) begin
         cycles++;
         @(negedge clock);
         #1;
      end
   endtask

   task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      int cycles;
      @(negedge clock);
      start_in = 1'b1; op_in = op; a_in = a; b_in = b;
      @(negedge clock);
      start_in = 1'b0;
      #1;
      cycles = 0;
      waitIdle(cycles);
      check({tag, "_lat"}, 64'(cycles), 64'd33);
      check({tag, "_done"}, 64'(done_out), 64'd1);
      check({tag, "_hilo"}, {hi_out, lo_out}, refModel(op, a, b));
      @(negedge clock);
      #1;
      check({tag, "_doneoff"}, 64'(done_out), 64'd0);
   endtask

   initial begin
      int cycles;
      int bad;
      int doneSeen;
      logic [31:0] loBefore, hiBefore, ra, rb;
      logic [1:0]  rop;

      reset = 1'b0; start_in = 1'b0; op_in = 2'b00; a_in = '0; b_in = '0;
      read_hilo_in = 1'b0; hi_we_in = 1'b0; lo_we_in = 1'b0; wdata_in = '0;
      #1;
      check("rst_hilo", {hi_out, lo_out}, 64'd0);
      check("rst_flags", {61'd0, busy_out, done_out, stall_out}, 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      check("multu_max_lit", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
      runOp(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, "mult_neg");
      check("mult_neg_lit", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);
      runOp(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
      check("div_neg_lit", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
      runOp(2'b11, 32'h0000_0064, 32'h0, "divu_zero");
      check("divu_zero_lit", {hi_out, lo_out}, 64'h0000_0064_FFFF_FFFF);
      runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      check("div_ovf_lit", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
      runOp(2'b10, 32'hFFFF_FFF9, 32'h0, "div_zero_neg");
      runOp(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minmin");

      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 7) == 0) rb = '0;
         else if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 20);
         if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
         runOp(rop, ra, rb, $sformatf("rnd%0d", i));
      end

      // MTHI alone, then both writes together.
      @(negedge clock);
      loBefore = lo_out;
      hi_we_in = 1'b1; wdata_in = 32'h1234_5678;
      @(negedge clock);
      hi_we_in = 1'b0;
      #1;
      check("mthi", {hi_out, lo_out}, {32'h1234_5678, loBefore});
      hi_we_in = 1'b1; lo_we_in = 1'b1; wdata_in = 32'hCAFE_F00D;
      @(negedge clock);
      hi_we_in = 1'b0; lo_we_in = 1'b0;
      #1;
      check("mthilo", {hi_out, lo_out}, {2{32'hCAFE_F00D}});

      // Start and MTHI together: start wins, write dropped.
      start_in = 1'b1; hi_we_in = 1'b1; op_in = 2'b01; a_in = 32'd9; b_in = 32'd11;
      wdata_in = 32'hAAAA_5555;
      @(negedge clock);
      start_in = 1'b0; hi_we_in = 1'b0;
      #1;
      check("start_wins_hi", 64'(hi_out), 64'hCAFE_F00D);
      cycles = 1;
      waitIdle(cycles);
      check("start_wins_res", {hi_out, lo_out}, 64'd99);

      // MULTU 3*5 with MFHI/MFLO request and a repeated start while busy.
      @(negedge clock);
      start_in = 1'b1; op_in = 2'b01; a_in = 32'd3; b_in = 32'd5;
      @(negedge clock);
      start_in = 1'b0;
      #1;
      loBefore = lo_out;
      check("stall_none", 64'(stall_out), 64'd0);
      @(negedge clock);
      read_hilo_in = 1'b1; start_in = 1'b1; a_in = 32'd7; b_in = 32'd7;
      #1;
      cycles = 1; bad = 0;
      while (busy_out && cycles < 100) begin
         cycles++;
         if (!stall_out || lo_out !== loBefore) bad++;
         @(negedge clock);
         #1;
      end
      start_in = 1'b0;
      #1;
      check("stall_lat", 64'(cycles), 64'd33);
      check("stall_busy", 64'(bad), 64'd0);
      check("stall_idle", 64'(stall_out), 64'd0);
      check("stall_res", {hi_out, lo_out}, 64'h0000_000F);
      read_hilo_in = 1'b0;
      @(negedge clock);
      #1;
      check("restart_ignored", 64'(busy_out), 64'd0);

      // MTLO while busy is held off.
      start_in = 1'b1; op_in = 2'b01; a_in = 32'h0001_0003; b_in = 32'h0000_0101;
      @(negedge clock);
      start_in = 1'b0; lo_we_in = 1'b1; wdata_in = 32'hDEAD_BEEF;
      #1;
      loBefore = lo_out;
      cycles = 1; bad = 0;
      check("mtlo_stall", 64'(stall_out), 64'd1);
      while (busy_out && cycles < 100) begin
         cycles++;
         if (!stall_out || lo_out !== loBefore) bad++;
         @(negedge clock);
         #1;
      end
      lo_we_in = 1'b0;
      check("mtlo_busy", 64'(bad), 64'd0);
      check("mtlo_res", {hi_out, lo_out}, refModel(2'b01, 32'h0001_0003, 32'h0000_0101));

      // Reset in the middle of a run.
      runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "pre_rst");
      @(negedge clock);
      start_in = 1'b1; op_in = 2'b01; a_in = 32'h1234_5678; b_in = 32'h9ABC_DEF0;
      @(negedge clock);
      start_in = 1'b0;
      repeat (10) @(negedge clock);
      reset = 1'b0;
      #1;
      check("midrst_hilo", {hi_out, lo_out}, 64'd0);
      check("midrst_busy", 64'(busy_out), 64'd0);
      doneSeen = 0;
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (done_out || busy_out) doneSeen++;
         @(negedge clock);
      end
      check("midrst_nodone", 64'(doneSeen), 64'd0);
      runOp(2'b01, 32'd2, 32'd2, "post_rst");
      check("post_rst_lo", 64'(lo_out), 64'd4);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
